// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FSM encoding, format helpers and datapath widths for the FPU blocks
package fpu_pkg;
  typedef logic [3:0] fsm_state_t;
  localparam fsm_state_t S_IDLE    = 4'd0;
  localparam fsm_state_t S_UNPACK  = 4'd1;
  localparam fsm_state_t S_SPECIAL = 4'd2;
  localparam fsm_state_t S_ALIGN   = 4'd3;
  localparam fsm_state_t S_ADD     = 4'd4;
  localparam fsm_state_t S_NORM    = 4'd5;
  localparam fsm_state_t S_ROUND   = 4'd6;
  localparam fsm_state_t S_PACK    = 4'd7;
  localparam fsm_state_t S_OUT     = 4'd8;
  localparam int GRS_W = 3;
  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  function automatic int fp_width(input int ew, input int mw);
    return 1 + ew + mw;
  endfunction
  function automatic int dp_width(input int mw);
    return mw + 2 + GRS_W;
  endfunction
  function automatic logic [255:0] qnan_pat(input int ew, input int mw);
    return ((256'(1) << (ew + 1)) - 256'(1)) << (mw - 1);
  endfunction
  function automatic logic [255:0] inf_pat(input int ew, input int mw);
    return ((256'(1) << ew) - 256'(1)) << mw;
  endfunction
endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: combinational leading-zero counter, returns N for an all-zero input
module fpu_lzc #(
  parameter int N = 27
) (
  input  logic [N-1:0]             din,
  output logic [$clog2(N+1)-1:0]   cnt
);
  localparam int CW = $clog2(N + 1);
  always_comb begin
    cnt = CW'(N);
    for (int i = 0; i < N; i++) if (din[i]) cnt = CW'(N - 1 - i);
  end
endmodule

// File: rtl/fp_addsub.sv
// fp_addsub: multi-cycle IEEE-754 add/sub with RNE and flags; FPU_ADDSUB_DENORM_EN enables subnormals
module fp_addsub
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   input_a,
  input  logic [EXP_W+MAN_W:0]   input_b,
  output logic [EXP_W+MAN_W:0]   output_z,
  output logic                   output_valid,
  input  logic                   ack_output,
  output logic                   idle_status,
  output logic                   flag_invalid,
  output logic                   flag_overflow,
  output logic                   flag_inexact
);
  localparam int W  = fp_width(EXP_W, MAN_W);
  localparam int DW = dp_width(MAN_W);
  localparam int XW = EXP_W + 2;
  localparam int LW = $clog2(DW);
  localparam logic [W-1:0] QNAN = W'(qnan_pat(EXP_W, MAN_W));
  localparam logic [W-1:0] INF  = W'(inf_pat(EXP_W, MAN_W));
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EMIN = XW'(1);
  fsm_state_t state;
  logic [W-1:0] in_a, in_b;
  logic sub_op, a_s, b_s, z_s, spec, rnd_inx;
  logic [XW-1:0] a_e, b_e, z_e;
  logic [MAN_W:0] a_m, b_m, r_m;
  logic [DW-1:0] xm, ym, z_m;
  // exponents are kept biased; subnormals and zeros sit at biased exponent 1
  function automatic logic [XW+MAN_W:0] unpack(input logic [W-2:0] v);
    logic [EXP_W-1:0] e;
    e = v[MAN_W +: EXP_W];
`ifdef FPU_ADDSUB_DENORM_EN
    return {e == '0 ? XW'(1) : XW'(e), e != '0, v[MAN_W-1:0]};
`else
    return {e == '0 ? XW'(1) : XW'(e), e == '0 ? (MAN_W+1)'(0) : {1'b1, v[MAN_W-1:0]}};
`endif
  endfunction
  logic a_inf, b_inf, a_nan, b_nan, a_zero, b_zero, sp_nan, sp_hit;
  logic [W-1:0] a_pk, b_pk, sp_z;
  assign a_inf  = &in_a[MAN_W +: EXP_W] && in_a[MAN_W-1:0] == '0;
  assign b_inf  = &in_b[MAN_W +: EXP_W] && in_b[MAN_W-1:0] == '0;
  assign a_nan  = &in_a[MAN_W +: EXP_W] && |in_a[MAN_W-1:0];
  assign b_nan  = &in_b[MAN_W +: EXP_W] && |in_b[MAN_W-1:0];
  assign a_zero = a_m == '0;
  assign b_zero = b_m == '0;
  assign sp_nan = a_nan | b_nan | (a_inf & b_inf & (a_s ^ b_s));
  assign sp_hit = sp_nan | a_inf | b_inf | a_zero | b_zero;
  assign a_pk   = {a_s, a_m[MAN_W] ? a_e[EXP_W-1:0] : EXP_W'(0), a_m[MAN_W-1:0]};
  assign b_pk   = {b_s, b_m[MAN_W] ? b_e[EXP_W-1:0] : EXP_W'(0), b_m[MAN_W-1:0]};
  assign sp_z   = sp_nan ? QNAN : a_inf ? {a_s, INF[W-2:0]} : b_inf ? {b_s, INF[W-2:0]} :
                  (a_zero & b_zero) ? {a_s & b_s, (W-1)'(0)} : a_zero ? b_pk : a_pk;
  logic a_big, x_s, lost;
  logic [XW-1:0] x_e, y_e, d;
  logic [MAN_W:0] x_m, y_m;
  logic [DW-1:0] yx, al_y, sum;
  assign a_big = {a_e, a_m} >= {b_e, b_m};
  assign x_s   = a_big ? a_s : b_s;
  assign x_e   = a_big ? a_e : b_e;
  assign y_e   = a_big ? b_e : a_e;
  assign x_m   = a_big ? a_m : b_m;
  assign y_m   = a_big ? b_m : a_m;
  assign d     = x_e - y_e;
  assign yx    = {1'b0, y_m, 3'b000};
  // any shift past the guard window leaves only the sticky bit
  assign lost  = |(yx & ~({DW{1'b1}} << d));
  assign al_y  = (yx >> d) | {(DW-1)'(0), lost};
  assign sum   = (a_s ^ b_s) ? xm - ym : xm + ym;
  logic [LW-1:0] lz;
  logic [XW-1:0] lzx, sh, nm_e;
  logic [DW-1:0] nm_m;
  fpu_lzc #(.N(DW - 1)) u_lzc (.din(z_m[DW-2:0]), .cnt(lz));
  assign lzx = XW'(lz);
`ifdef FPU_ADDSUB_DENORM_EN
  assign sh = lzx > z_e - XW'(1) ? z_e - XW'(1) : lzx;
`else
  assign sh = lzx;
`endif
  assign nm_e = z_m[DW-1] ? z_e + XW'(1) : z_e - sh;
  assign nm_m = z_m[DW-1] ? {1'b0, z_m[DW-1:2], |z_m[1:0]} : z_m << sh;
  logic rnd_up, tiny, ovf, pk_inx;
  logic [MAN_W+1:0] rm;
  logic [W-1:0] pk_z;
  assign rnd_up = z_m[2] & (z_m[1] | z_m[0] | z_m[3]);
  assign rm     = {1'b0, z_m[DW-2:3]} + (MAN_W+2)'(rnd_up);
`ifdef FPU_ADDSUB_DENORM_EN
  assign tiny = 1'b0;
`else
  assign tiny = $signed(z_e) < EMIN;
`endif
  assign ovf    = $signed(z_e) >= EMAX;
  assign pk_inx = tiny | ovf | rnd_inx;
  assign pk_z   = tiny ? {z_s, (W-1)'(0)} : ovf ? {z_s, INF[W-2:0]} :
                  {z_s, r_m[MAN_W] ? z_e[EXP_W-1:0] : EXP_W'(0), r_m[MAN_W-1:0]};
  assign output_valid = state == S_OUT;
  assign idle_status  = state == S_IDLE;
  // special results also pass through PACK, which leaves them untouched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= S_IDLE;
      output_z      <= '0;
      flag_invalid  <= 1'b0;
      flag_overflow <= 1'b0;
      flag_inexact  <= 1'b0;
    end else
      case (state)
        S_IDLE: if (start) begin
          state         <= S_UNPACK;
          flag_invalid  <= 1'b0;
          flag_overflow <= 1'b0;
          flag_inexact  <= 1'b0;
        end
        S_UNPACK: state <= S_SPECIAL;
        S_SPECIAL: begin
          state <= sp_hit ? S_PACK : S_ALIGN;
          if (sp_hit) begin
            output_z     <= sp_z;
            flag_invalid <= sp_nan;
          end
        end
        S_ALIGN: state <= S_ADD;
        S_ADD: begin
          state <= S_NORM;
          if (sum == '0) output_z <= '0;
        end
        S_NORM: state <= S_ROUND;
        S_ROUND: state <= S_PACK;
        S_PACK: begin
          state <= S_OUT;
          if (!spec) begin
            output_z      <= pk_z;
            flag_overflow <= ovf;
            flag_inexact  <= pk_inx;
          end
        end
        S_OUT: if (ack_output) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
  always_ff @(posedge clk)
    case (state)
      S_IDLE: if (start) begin
        in_a   <= input_a;
        in_b   <= input_b;
        sub_op <= op_sub;
      end
      S_UNPACK: begin
        a_s        <= in_a[W-1];
        b_s        <= in_b[W-1] ^ sub_op;
        {a_e, a_m} <= unpack(in_a[W-2:0]);
        {b_e, b_m} <= unpack(in_b[W-2:0]);
      end
      S_SPECIAL: spec <= sp_hit;
      S_ALIGN: begin
        xm  <= {1'b0, x_m, 3'b000};
        ym  <= al_y;
        z_e <= x_e;
        z_s <= x_s;
      end
      S_ADD: begin
        z_m  <= sum;
        spec <= sum == '0;
      end
      S_NORM: begin
        z_m <= nm_m;
        z_e <= nm_e;
      end
      S_ROUND: begin
        r_m     <= rm[MAN_W+1] ? rm[MAN_W+1:1] : rm[MAN_W:0];
        z_e     <= z_e + XW'(rm[MAN_W+1]);
        rnd_inx <= |z_m[2:0];
      end
      default: ;
    endcase
endmodule

// File: tb/tb_fp_addsub.sv
// tb_fp_addsub: directed vectors checked by a queue-based scoreboard monitor
module tb_fp_addsub;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, op_sub = 1'b0, ack_output = 1'b0;
  logic [31:0] input_a = '0, input_b = '0, output_z;
  logic output_valid, idle_status, flag_invalid, flag_overflow, flag_inexact;
  typedef struct {
    logic [31:0] z;
    logic [2:0]  fl;
    int          lat;
    int          st;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  int checks = 0, errors = 0, cyc = 0;
  logic prev_v = 1'b0;
  fp_addsub dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .input_a(input_a), .input_b(input_b), .output_z(output_z),
    .output_valid(output_valid), .ack_output(ack_output), .idle_status(idle_status),
    .flag_invalid(flag_invalid), .flag_overflow(flag_overflow), .flag_inexact(flag_inexact)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, want);
    end
  endtask
  always @(negedge clk) begin
    if (output_valid && !prev_v) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h with no expected entry", output_z);
      end else begin
        cur = q.pop_front();
        chk("result_z", output_z, cur.z);
        chk("flags_ivo_ovf_inx", {29'd0, flag_invalid, flag_overflow, flag_inexact}, {29'd0, cur.fl});
        chk("latency", 32'(cyc - cur.st), 32'(cur.lat));
      end
    end else if (output_valid) chk("hold_z", output_z, cur.z);
    prev_v = output_valid;
  end
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic sub,
                     input logic [31:0] z, input logic [2:0] fl, input int lat,
                     input int hold, input bit early);
    int n;
    n = 0;
    while (!idle_status && n < 50) begin @(negedge clk); n++; end
    if (!idle_status) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: idle_status %b expected 1", idle_status);
      return;
    end
    input_a = a;
    input_b = b;
    op_sub = sub;
    start = 1'b1;
    ack_output = early;
    q.push_back('{z: z, fl: fl, lat: lat, st: cyc + 1});
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!output_valid && n < 50) begin @(negedge clk); n++; end
    if (!output_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: output_valid %b expected 1", output_valid);
      return;
    end
    repeat (hold) @(negedge clk);
    ack_output = 1'b1;
    @(negedge clk);
    ack_output = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    #12;
    chk("rst_valid", {31'd0, output_valid}, 32'd0);
    chk("rst_idle", {31'd0, idle_status}, 32'd1);
    chk("rst_z", output_z, 32'd0);
    chk("rst_flags", {29'd0, flag_invalid, flag_overflow, flag_inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 3'b000, 7, 5, 1'b0);
    run(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 7, 0, 1'b0);
    run(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 3, 0, 1'b0);
    run(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, 3, 0, 1'b0);
    run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 7, 0, 1'b0);
    run(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 7, 0, 1'b0);
    run(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b001, 7, 0, 1'b0);
    run(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001, 7, 0, 1'b0);
    run(32'h40000000, 32'h3F000000, 1'b1, 32'h3FC00000, 3'b000, 7, 0, 1'b1);
    run(32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 3'b000, 7, 2, 1'b0);
    run(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, 3, 0, 1'b0);
    run(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000, 3, 0, 1'b0);
    run(32'h3F800000, 32'h80000000, 1'b0, 32'h3F800000, 3'b000, 3, 0, 1'b0);
`ifdef FPU_ADDSUB_DENORM_EN
    run(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000, 7, 0, 1'b0);
`else
    run(32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 3'b000, 3, 0, 1'b0);
`endif
    run(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000, 7, 0, 1'b0);
    input_a = 32'h3FC00000;
    input_b = 32'h40100000;
    op_sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("align_busy", {31'd0, idle_status}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, output_valid}, 32'd0);
    chk("midrst_idle", {31'd0, idle_status}, 32'd1);
    chk("midrst_z", output_z, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 3'b000, 7, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
